// File: rtl/gametank_bus_uart.sv
// CPU-mapped 8N1 UART: register 0 = TX push / RX pop, register 1 = status / overrun clear.
// Bus writes land in the TX FIFO the cycle the strobe edge is seen; pushes to a full FIFO are dropped.
module gametank_bus_uart #(
   parameter logic [15:0] BASE_ADDR  = 16'h2008,
   parameter int          CLK_DIV    = 234,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        sys_clk,
   input  logic        reset2,
   input  logic [15:0] AB,
   input  logic [7:0]  DB_W,
   input  logic        nRD,
   input  logic        nWR,
   output logic [7:0]  DB_R,
   output logic        sel,
   input  logic        UART_RXD,
   output logic        UART_TXD
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
   localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic r_nrd_q, r_nwr_q;
   logic w_rd0, w_wr0, w_wr1, w_is_reg0;

   assign sel       = (AB == BASE_ADDR) || (AB == BASE_ADDR + 16'd1);
   assign w_is_reg0 = (AB == BASE_ADDR);
   assign w_rd0     = sel && !nRD && r_nrd_q && w_is_reg0;
   assign w_wr0     = sel && !nWR && r_nwr_q && w_is_reg0;
   assign w_wr1     = sel && !nWR && r_nwr_q && !w_is_reg0;

   always_ff @(posedge sys_clk or posedge reset2) begin
      if (reset2) begin
         r_nrd_q <= 1'b1;
         r_nwr_q <= 1'b1;
      end else begin
         r_nrd_q <= nRD;
         r_nwr_q <= nWR;
      end
   end

   // TX FIFO: a pop frees the slot the same cycle, so push+pop on a full FIFO both proceed.
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_cnt;
   logic          w_empty, w_full, w_push, w_pop;

   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == FULL_CNT);
   assign w_push  = w_wr0 && (!w_full || w_pop);

   always_ff @(posedge sys_clk) begin
      if (w_push) r_mem[r_wptr] <= DB_W;
   end

   always_ff @(posedge sys_clk or posedge reset2) begin
      if (reset2) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   state_t      r_tx_state, w_tx_state;
   logic [15:0] r_tx_cnt, w_tx_cnt;
   logic [2:0]  r_tx_bit, w_tx_bit;
   logic [7:0]  r_tx_shift, w_tx_shift;
   logic        r_txd, w_txd, w_tx_end, w_tx_busy;

   assign w_tx_end  = (r_tx_cnt == DIV_LAST);
   assign w_tx_busy = (r_tx_state != S_IDLE);
   assign UART_TXD  = r_txd;

   always_ff @(posedge sys_clk or posedge reset2) begin
      if (reset2) begin
         r_tx_state <= S_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_txd      <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state;
         r_tx_cnt   <= w_tx_cnt;
         r_tx_bit   <= w_tx_bit;
         r_tx_shift <= w_tx_shift;
         r_txd      <= w_txd;
      end
   end

   always_comb begin
      w_tx_state = r_tx_state;
      w_tx_cnt   = r_tx_cnt + 16'd1;
      w_tx_bit   = r_tx_bit;
      w_tx_shift = r_tx_shift;
      w_txd      = r_txd;
      w_pop      = 1'b0;
      case (r_tx_state)
         S_IDLE: begin
            w_tx_cnt = '0;
            if (!w_empty) begin
               w_pop      = 1'b1;
               w_tx_shift = r_mem[r_rptr];
               w_txd      = 1'b0;
               w_tx_state = S_START;
            end
         end
         S_START: if (w_tx_end) begin
            w_tx_cnt   = '0;
            w_tx_bit   = '0;
            w_txd      = r_tx_shift[0];
            w_tx_state = S_DATA;
         end
         S_DATA: if (w_tx_end) begin
            w_tx_cnt   = '0;
            w_tx_shift = {1'b0, r_tx_shift[7:1]};
            w_tx_bit   = r_tx_bit + 3'd1;
            w_txd      = r_tx_shift[1];
            if (r_tx_bit == 3'd7) begin
               w_txd      = 1'b1;
               w_tx_state = S_STOP;
            end
         end
         S_STOP: if (w_tx_end) begin
            w_tx_cnt = '0;
            if (!w_empty) begin
               w_pop      = 1'b1;
               w_tx_shift = r_mem[r_rptr];
               w_txd      = 1'b0;
               w_tx_state = S_START;
            end else begin
               w_tx_state = S_IDLE;
            end
         end
         default: w_tx_state = S_IDLE;
      endcase
   end

   state_t      r_rx_state, w_rx_state;
   logic [15:0] r_rx_cnt, w_rx_cnt;
   logic [2:0]  r_rx_bit, w_rx_bit;
   logic [7:0]  r_rx_shift, w_rx_shift, r_rx_data;
   logic        r_rx_s1, r_rx_s2, r_rx_prev, r_rx_valid, r_rx_ovr, w_rx_done;

   always_ff @(posedge sys_clk or posedge reset2) begin
      if (reset2) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= S_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_rx_ovr   <= 1'b0;
      end else begin
         r_rx_s1    <= UART_RXD;
         r_rx_s2    <= r_rx_s1;
         r_rx_prev  <= r_rx_s2;
         r_rx_state <= w_rx_state;
         r_rx_cnt   <= w_rx_cnt;
         r_rx_bit   <= w_rx_bit;
         r_rx_shift <= w_rx_shift;
         if (w_wr1) r_rx_ovr <= 1'b0;
         // A register-0 read in the completion cycle frees the holding register for the new byte.
         if (w_rx_done) begin
            if (!r_rx_valid || w_rd0) begin
               r_rx_data  <= r_rx_shift;
               r_rx_valid <= 1'b1;
            end else begin
               r_rx_ovr <= 1'b1;
            end
         end else if (w_rd0) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      w_rx_state = r_rx_state;
      w_rx_cnt   = r_rx_cnt + 16'd1;
      w_rx_bit   = r_rx_bit;
      w_rx_shift = r_rx_shift;
      w_rx_done  = 1'b0;
      case (r_rx_state)
         S_IDLE: begin
            w_rx_cnt = '0;
            if (r_rx_prev && !r_rx_s2) w_rx_state = S_START;
         end
         S_START: if (r_rx_cnt == HALF_LAST) begin
            w_rx_cnt   = '0;
            w_rx_bit   = '0;
            w_rx_state = r_rx_s2 ? S_IDLE : S_DATA;
         end
         S_DATA: if (r_rx_cnt == DIV_LAST) begin
            w_rx_cnt   = '0;
            w_rx_shift = {r_rx_s2, r_rx_shift[7:1]};
            w_rx_bit   = r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) w_rx_state = S_STOP;
         end
         S_STOP: if (r_rx_cnt == DIV_LAST) begin
            w_rx_done  = r_rx_s2;
            w_rx_state = S_IDLE;
         end
         default: w_rx_state = S_IDLE;
      endcase
   end

   always_comb begin
      DB_R = 8'h00;
      if (sel) begin
         if (w_is_reg0) DB_R = r_rx_valid ? r_rx_data : 8'h00;
         else           DB_R = {3'b000, r_rx_ovr, w_tx_busy, w_empty, w_full, r_rx_valid};
      end
   end
endmodule

// File: doc/gametank_bus_uart.md
GAMETANK_BUS_UART -- requirements
Module: gametank_bus_uart

Parameters
REQ-001 BASE_ADDR, 16'h2008, CPU address of register 0; register 1 is at BASE_ADDR+1.
REQ-002 CLK_DIV, 234, sys_clk cycles per serial bit (234 gives 115200 baud at 27 MHz); legal range 16..65535.
REQ-003 FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.

Interface
REQ-004 sys_clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset2  in  1  asynchronous, active-high reset.
REQ-006 AB  in  16  CPU address bus.
REQ-007 DB_W  in  8  CPU write data.
REQ-008 nRD  in  1  CPU read strobe, active-low.
REQ-009 nWR  in  1  CPU write strobe, active-low.
REQ-010 DB_R  out  8  read data returned to the CPU.
REQ-011 sel  out  1  high when AB equals BASE_ADDR or BASE_ADDR+1; combinational.
REQ-012 UART_RXD  in  1  serial input, asynchronous to sys_clk.
REQ-013 UART_TXD  out  1  serial output, 8N1 format, idle high.

Function
REQ-014 Bus access: each strobe falling edge counts as one access, taken on the first cycle the strobe is low (previous sample high) while sel=1; a strobe held low produces no further accesses.
REQ-015 Register 0 write: pushes DB_W into the TX FIFO; a push to a full FIFO is dropped and no state changes.
REQ-016 Register 0 read: DB_R = rx_data when rx_valid=1, otherwise 8'h00; the access clears rx_valid.
REQ-017 Register 1 read: DB_R = {3'b0, rx_overrun, tx_busy, tx_empty, tx_full, rx_valid}; no side effects.
REQ-018 Register 1 write: any value clears rx_overrun.
REQ-019 DB_R is combinational from AB and current state whenever sel=1, and 8'h00 when sel=0.
REQ-020 TX FIFO: FIFO order is preserved; pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1 bits; a push and a pop in the same cycle are both performed, including when the FIFO is full.
REQ-021 TX state machine states: IDLE, START, DATA, STOP.
- IDLE -> START when the FIFO is not empty; the FIFO pops into the shift register in that cycle.
- START, DATA (8 bits, LSB first) and STOP each hold for CLK_DIV cycles per bit.
- STOP -> START directly when the FIFO is not empty; otherwise STOP -> IDLE.
REQ-022 TX timing: UART_TXD is registered; the start bit begins 1 cycle after the pop; one frame is exactly 10*CLK_DIV cycles; tx_busy=1 in every state except IDLE.
REQ-023 RX input path: UART_RXD passes through a 2-flop synchronizer.
REQ-024 RX state machine states: IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized falling edge.
- START re-samples at CLK_DIV/2 cycles; if the line is high, return to IDLE (glitch rejected).
- DATA samples 8 bits, LSB first, each CLK_DIV cycles after the previous sample.
- STOP samples once more.
REQ-025 RX stop bit high: the byte is written to rx_data and rx_valid is set to 1. If rx_valid was already 1, the new byte is discarded, rx_data is kept and rx_overrun is set to 1.
REQ-026 RX stop bit low (framing error): the byte is discarded and the state returns to IDLE.
REQ-027 RX byte completing in the same cycle as a register 0 read: the new byte is stored, rx_valid ends at 1 and no overrun is flagged.

Reset
REQ-028 While reset2=1, all state is held at reset values: FIFO empty, both state machines IDLE, UART_TXD=1, rx_valid=0, rx_overrun=0, rx_data=8'h00, strobe edge samples=1.
REQ-029 Reset in the middle of a frame aborts it immediately; UART_TXD goes high asynchronously, and operation resumes on the first clock edge after reset2 falls.

Verification
REQ-030 Write 8'hA5 to BASE_ADDR -> UART_TXD low 1 cycle later for 234 cycles, then bits 1,0,1,0,0,1,0,1, then high; tx_busy falls 2340 cycles after start.
REQ-031 Write 9 bytes back-to-back to BASE_ADDR with CLK_DIV=16 -> the first byte starts, the remaining 8 fill the FIFO (tx_full=1); a 10th write is dropped; exactly 9 frames go out with no idle gap between them.
REQ-032 Drive an 8N1 frame carrying 8'h3C on UART_RXD -> STATUS reads 8'h05 (tx_empty and rx_valid set); DATA read returns 8'h3C; STATUS then reads 8'h04.
REQ-033 Drive two frames without reading -> rx_overrun=1 and DATA returns the first byte; a STATUS write clears the overrun.
REQ-034 Send a 0.3-bit low glitch, then a frame with a low stop bit -> rx_valid stays 0.
REQ-035 Assert reset2 mid-TX-frame -> UART_TXD=1 and tx_empty=1 immediately; a subsequent write transmits normally.
